// File: rtl/ibex_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : ibex_perf_counters
// Purpose  : Machine counter/timer unit for the ibex CSR path. Holds mcycle,
//            minstret, mhpmcounter3..3+NUM_HPM-1 and mcountinhibit, and
//            answers CSR accesses in 0xB00-0xB9F and 0x320 with a fixed
//            one-cycle registered read latency.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            csr_req_i            - one-cycle CSR access strobe
//            csr_addr_i           - 12-bit CSR address
//            csr_we_i             - write enable (qualified by csr_req_i)
//            csr_wdata_i          - 32-bit write data
//            csr_rvalid_o         - response strobe, cycle after csr_req_i
//            csr_rdata_o          - response data (value before the access)
//            csr_hit_o            - address belongs to this block
//            instr_ret_i          - instruction retired (minstret event)
//            hpm_event_i          - per-mhpmcounter increment events
//            debug_mode_i         - core in debug mode
//            dcsr_stopcount_i     - dcsr.stopcount, freezes counting in debug
// Options  : IBEX_PERF_HI_SNAPSHOT_EN - when defined, a low-half read latches
//            the upper 32 bits of that counter into a shared shadow so the
//            following high-half read returns a consistent 64-bit pair.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_perf_counters #(
   parameter int unsigned NUM_HPM   = 2,
   parameter int unsigned HPM_WIDTH = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_req_i,
   input  logic [11:0]        csr_addr_i,
   input  logic               csr_we_i,
   input  logic [31:0]        csr_wdata_i,
   output logic               csr_rvalid_o,
   output logic [31:0]        csr_rdata_o,
   output logic               csr_hit_o,
   input  logic               instr_ret_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   input  logic               debug_mode_i,
   input  logic               dcsr_stopcount_i
);

   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   // Counter address blocks: addr[11:5] selects 0xB00-0xB1F / 0xB80-0xB9F
   localparam logic [6:0]  CNT_LO_PAGE       = 7'b1011_000;
   localparam logic [6:0]  CNT_HI_PAGE       = 7'b1011_100;
   // Writable mcountinhibit bits: CY (0), IR (2) and one per implemented hpm
   localparam logic [31:0] HPM_INH_MASK      = ((32'h1 << NUM_HPM) - 32'h1) << 3;
   localparam logic [31:0] INHIBIT_MASK      = HPM_INH_MASK | 32'h0000_0005;
   localparam logic [HPM_WIDTH-1:0] HPM_ONE  = {{(HPM_WIDTH-1){1'b0}}, 1'b1};

   // Replace one 32-bit half of a 64-bit counter, keeping the other half
   function automatic logic [63:0] f_merge(input logic [63:0] old_val,
                                           input logic        hi_half,
                                           input logic [31:0] wdata);
      f_merge = hi_half ? {wdata, old_val[31:0]} : {old_val[63:32], wdata};
   endfunction

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic [4:0] w_idx;
   logic       w_lo_sel;
   logic       w_hi_sel;
   logic       w_cnt_sel;
   logic       w_inh_sel;
   logic       w_hit;
   logic       w_wr;
   logic       w_cnt_wr;
   logic       w_count_ok;

   assign w_idx      = csr_addr_i[4:0];
   assign w_lo_sel   = (csr_addr_i[11:5] == CNT_LO_PAGE);
   assign w_hi_sel   = (csr_addr_i[11:5] == CNT_HI_PAGE);
   // Index 1 (0xB01/0xB81) is not a machine counter and stays outside the map
   assign w_cnt_sel  = (w_lo_sel | w_hi_sel) & (w_idx != 5'd1);
   assign w_inh_sel  = (csr_addr_i == CSR_MCOUNTINHIBIT);
   assign w_hit      = w_cnt_sel | w_inh_sel;
   assign w_wr       = csr_req_i & csr_we_i;
   assign w_cnt_wr   = w_wr & w_cnt_sel;
   assign w_count_ok = ~(debug_mode_i & dcsr_stopcount_i);

   // ------------------------------------------------------------------------
   // Counter state
   // ------------------------------------------------------------------------
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic [31:0] mcountinhibit_q, mcountinhibit_d;
   logic [63:0] w_hpm_view [NUM_HPM];

   always_comb begin
      mcycle_d = mcycle_q;
      if (w_cnt_wr && (w_idx == 5'd0)) begin
         mcycle_d = f_merge(mcycle_q, w_hi_sel, csr_wdata_i);
      end else if (w_count_ok && !mcountinhibit_q[0]) begin
         mcycle_d = mcycle_q + 64'd1;
      end
   end

   always_comb begin
      minstret_d = minstret_q;
      if (w_cnt_wr && (w_idx == 5'd2)) begin
         minstret_d = f_merge(minstret_q, w_hi_sel, csr_wdata_i);
      end else if (w_count_ok && !mcountinhibit_q[2] && instr_ret_i) begin
         minstret_d = minstret_q + 64'd1;
      end
   end

   always_comb begin
      mcountinhibit_d = mcountinhibit_q;
      if (w_wr && w_inh_sel) begin
         mcountinhibit_d = csr_wdata_i & INHIBIT_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_q        <= '0;
         minstret_q      <= '0;
         mcountinhibit_q <= '0;
      end else begin
         mcycle_q        <= mcycle_d;
         minstret_q      <= minstret_d;
         mcountinhibit_q <= mcountinhibit_d;
      end
   end

   for (genvar n = 0; n < NUM_HPM; n++) begin : g_hpm
      logic [HPM_WIDTH-1:0] hpm_q, hpm_d;
      logic                 w_wr_this;

      assign w_wr_this = w_cnt_wr && (w_idx == 5'(n + 3));

      always_comb begin
         hpm_d = hpm_q;
         if (w_wr_this) begin
            // High-half writes keep only the implemented bits above 31
            hpm_d = w_hi_sel ? {csr_wdata_i[HPM_WIDTH-33:0], hpm_q[31:0]}
                             : {hpm_q[HPM_WIDTH-1:32], csr_wdata_i};
         end else if (w_count_ok && !mcountinhibit_q[n+3] && hpm_event_i[n]) begin
            hpm_d = hpm_q + HPM_ONE;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hpm_q <= '0;
         end else begin
            hpm_q <= hpm_d;
         end
      end

      assign w_hpm_view[n] = 64'(hpm_q);
   end

   // ------------------------------------------------------------------------
   // Read path (old value, registered)
   // ------------------------------------------------------------------------
   // Counter selected by the address index; unimplemented indices read zero
   logic [63:0] w_sel_cnt;
   logic [31:0] w_hi_rdata;
   logic [31:0] w_rdata;

   always_comb begin
      w_sel_cnt = '0;
      if (w_idx == 5'd0) begin
         w_sel_cnt = mcycle_q;
      end else if (w_idx == 5'd2) begin
         w_sel_cnt = minstret_q;
      end else begin
         for (int n = 0; n < int'(NUM_HPM); n++) begin
            if (w_idx == 5'(n + 3)) begin
               w_sel_cnt = w_hpm_view[n];
            end
         end
      end
   end

`ifdef IBEX_PERF_HI_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_d;
   logic [4:0]  tag_q, tag_d;
   logic        tag_vld_q, tag_vld_d;
   logic        w_rd;
   logic        w_impl;

   assign w_rd   = csr_req_i & ~csr_we_i;
   assign w_impl = (w_idx == 5'd0) || (w_idx == 5'd2) ||
                   ((w_idx >= 5'd3) && ({27'd0, w_idx} < 32'(3 + NUM_HPM)));

   always_comb begin
      shadow_d  = shadow_q;
      tag_d     = tag_q;
      tag_vld_d = tag_vld_q;
      if (w_cnt_wr && (w_idx == tag_q)) begin
         // Any write to the tagged counter makes the shadow stale
         tag_vld_d = 1'b0;
      end else if (w_rd && w_lo_sel && w_impl) begin
         shadow_d  = w_sel_cnt[63:32];
         tag_d     = w_idx;
         tag_vld_d = 1'b1;
      end else if (w_rd && w_hi_sel && w_cnt_sel && (w_idx != tag_q)) begin
         tag_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         tag_q     <= '0;
         tag_vld_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         tag_q     <= tag_d;
         tag_vld_q <= tag_vld_d;
      end
   end

   assign w_hi_rdata = (w_rd && tag_vld_q && (tag_q == w_idx)) ? shadow_q
                                                               : w_sel_cnt[63:32];
`else
   assign w_hi_rdata = w_sel_cnt[63:32];
`endif

   always_comb begin
      w_rdata = '0;
      if (w_inh_sel) begin
         w_rdata = mcountinhibit_q;
      end else if (w_cnt_sel && w_lo_sel) begin
         w_rdata = w_sel_cnt[31:0];
      end else if (w_cnt_sel && w_hi_sel) begin
         w_rdata = w_hi_rdata;
      end
   end

   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        hit_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         hit_q    <= 1'b0;
      end else begin
         rvalid_q <= csr_req_i;
         rdata_q  <= csr_req_i ? w_rdata : 32'd0;
         hit_q    <= csr_req_i & w_hit;
      end
   end

   assign csr_rvalid_o = rvalid_q;
   assign csr_rdata_o  = rdata_q;
   assign csr_hit_o    = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_perf_counters
// Purpose  : Self-checking bench for ibex_perf_counters. Directed steps for
//            the key scenarios followed by a randomized phase; every response
//            is compared with a behavioural model of the counter rules.
//            Honours IBEX_PERF_HI_SNAPSHOT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_perf_counters;

   localparam int NUM_HPM   = 2;
   localparam int HPM_WIDTH = 40;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               csr_req = 1'b0;
   logic [11:0]        csr_addr = '0;
   logic               csr_we = 1'b0;
   logic [31:0]        csr_wdata = '0;
   logic               csr_rvalid;
   logic [31:0]        csr_rdata;
   logic               csr_hit;
   logic               instr_ret = 1'b0;
   logic [NUM_HPM-1:0] hpm_event = '0;
   logic               debug_mode = 1'b0;
   logic               stopcount = 1'b0;

   always #5 clk = ~clk;

   ibex_perf_counters #(
      .NUM_HPM   (NUM_HPM),
      .HPM_WIDTH (HPM_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .csr_req_i        (csr_req),
      .csr_addr_i       (csr_addr),
      .csr_we_i         (csr_we),
      .csr_wdata_i      (csr_wdata),
      .csr_rvalid_o     (csr_rvalid),
      .csr_rdata_o      (csr_rdata),
      .csr_hit_o        (csr_hit),
      .instr_ret_i      (instr_ret),
      .hpm_event_i      (hpm_event),
      .debug_mode_i     (debug_mode),
      .dcsr_stopcount_i (stopcount)
   );

   // Reference model: counters indexed by CSR number, plain 64-bit arithmetic
   longint unsigned m_cnt [32];
   logic [31:0]     m_inh;
   logic [31:0]     m_shadow;
   int              m_tag;
   bit              m_tag_vld;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] last_rdata;
   logic        last_hit;

   function automatic bit is_impl(input int i);
      return (i == 0) || (i == 2) || ((i >= 3) && (i < 3 + NUM_HPM));
   endfunction

   function automatic longint unsigned cmask(input int i);
      if (i >= 3) return (64'd1 << HPM_WIDTH) - 64'd1;
      return 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   // 0: outside map, 1: counter low half, 2: counter high half, 3: mcountinhibit
   function automatic int kind_of(input logic [11:0] a, output int idx);
      idx = 0;
      if (a == 12'h320) return 3;
      if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) begin
         idx = int'(a - 12'hB00);
         return 1;
      end
      if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) begin
         idx = int'(a - 12'hB80);
         return 2;
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: predict the response from the model, advance model and DUT,
   // then compare just after the edge.
   task automatic tick();
      int          k, idx;
      bit          ok, ev, was_rst;
      logic        exp_valid, exp_hit;
      logic [31:0] exp_rdata, inh_mask;
      was_rst = rst;
      k = kind_of(csr_addr, idx);
      exp_valid = 1'b0;
      exp_hit   = 1'b0;
      exp_rdata = '0;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         m_inh     = '0;
         m_shadow  = '0;
         m_tag     = 0;
         m_tag_vld = 0;
      end else begin
         exp_valid = csr_req;
         exp_hit   = csr_req && (k != 0);
         if (csr_req) begin
            if (k == 3) exp_rdata = m_inh;
            else if (k == 1 && is_impl(idx)) exp_rdata = 32'(m_cnt[idx]);
            else if (k == 2 && is_impl(idx)) begin
               exp_rdata = 32'(m_cnt[idx] >> 32);
`ifdef IBEX_PERF_HI_SNAPSHOT_EN
               if (!csr_we && m_tag_vld && m_tag == idx) exp_rdata = m_shadow;
`endif
            end
         end
`ifdef IBEX_PERF_HI_SNAPSHOT_EN
         if (csr_req && csr_we) begin
            if ((k == 1 || k == 2) && m_tag_vld && m_tag == idx) m_tag_vld = 0;
         end else if (csr_req && k == 1 && is_impl(idx)) begin
            m_shadow  = 32'(m_cnt[idx] >> 32);
            m_tag     = idx;
            m_tag_vld = 1;
         end else if (csr_req && k == 2 && idx != m_tag) begin
            m_tag_vld = 0;
         end
`endif
         ok = !(debug_mode && stopcount);
         for (int i = 0; i < 32; i++) begin
            if (!is_impl(i)) continue;
            ev = (i == 0) ? 1'b1 : (i == 2) ? instr_ret : hpm_event[i-3];
            if (csr_req && csr_we && (k == 1 || k == 2) && idx == i) begin
               if (k == 1) m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | {32'h0, csr_wdata};
               else        m_cnt[i] = (m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | ({32'h0, csr_wdata} << 32);
               m_cnt[i] = m_cnt[i] & cmask(i);
            end else if (ok && !m_inh[i] && ev) begin
               m_cnt[i] = (m_cnt[i] + 64'd1) & cmask(i);
            end
         end
         if (csr_req && csr_we && k == 3) begin
            inh_mask = '0;
            for (int i = 0; i < 32; i++) if (is_impl(i)) inh_mask[i] = 1'b1;
            m_inh = csr_wdata & inh_mask;
         end
      end
      @(posedge clk);
      #1;
      chk("rvalid", {31'd0, csr_rvalid}, {31'd0, exp_valid});
      if (exp_valid || was_rst) begin
         chk("rdata", csr_rdata, exp_rdata);
         chk("hit", {31'd0, csr_hit}, {31'd0, exp_hit});
      end
      last_rdata = csr_rdata;
      last_hit   = csr_hit;
   endtask

   task automatic rd(input logic [11:0] a);
      csr_req = 1'b1; csr_we = 1'b0; csr_addr = a;
      tick();
      csr_req = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_req = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      tick();
      csr_req = 1'b0; csr_we = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] addr_tab [15];
      addr_tab = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04,
                   12'hB84, 12'hB05, 12'hB85, 12'hB1F, 12'hB9F, 12'hB01, 12'h320, 12'hC00};

      // Reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Free-running mcycle after reset
      repeat (10) tick();
      rd(12'hB00); chk("mcycle_after_10", last_rdata, 32'd10);
      chk("mcycle_hit", {31'd0, last_hit}, 32'd1);
      rd(12'hB80); chk("mcycleh_after_10", last_rdata, 32'd0);
      rd(12'hB02); chk("minstret_idle", last_rdata, 32'd0);

      // Write beats increment, carry into high half
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0000_0001);
      rd(12'hB00); chk("mcycle_written_lo", last_rdata, 32'hFFFF_FFFF);
      rd(12'hB80); chk("mcycle_carry_hi", last_rdata, 32'd2);

      // mcountinhibit freezes CY and IR
      wr(12'h320, 32'h0000_0005);
      instr_ret = 1'b1;
      repeat (4) tick();
      instr_ret = 1'b0;
      rd(12'h320); chk("inhibit_read", last_rdata, 32'h5);
      rd(12'hB02); chk("minstret_frozen", last_rdata, 32'd0);
      rd(12'hB00); rd(12'hB00);
      wr(12'h320, 32'hFFFF_FFFF);
      rd(12'h320); chk("inhibit_mask", last_rdata, 32'h0000_001D);
      wr(12'h320, 32'h0);
      instr_ret = 1'b1;
      repeat (3) tick();
      instr_ret = 1'b0;
      rd(12'hB02); chk("minstret_resumed", last_rdata, 32'd3);

      // Debug stopcount
      debug_mode = 1'b1; stopcount = 1'b1; hpm_event = '1;
      repeat (5) tick();
      rd(12'hB03); chk("hpm3_stopped", last_rdata, 32'd0);
      stopcount = 1'b0;
      repeat (3) tick();
      hpm_event = '0;
      rd(12'hB03); chk("hpm3_counting", last_rdata, 32'd3);
      rd(12'hB04); chk("hpm4_counting", last_rdata, 32'd3);
      debug_mode = 1'b0;

      // hpm wrap at HPM_WIDTH, unimplemented and unmapped addresses
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      rd(12'hB83); chk("hpm3_hi_trunc", last_rdata, 32'h0000_00FF);
      hpm_event = 2'b01;
      tick();
      hpm_event = '0;
      rd(12'hB83); chk("hpm3_wrap_hi", last_rdata, 32'd0);
      rd(12'hB03); chk("hpm3_wrap_lo", last_rdata, 32'd0);
      wr(12'hB1F, 32'h1234_5678);
      rd(12'hB1F); chk("unimpl_lo", last_rdata, 32'd0);
      chk("unimpl_lo_hit", {31'd0, last_hit}, 32'd1);
      rd(12'hB9F); chk("unimpl_hi", last_rdata, 32'd0);
      chk("unimpl_hi_hit", {31'd0, last_hit}, 32'd1);
      rd(12'hC00); chk("unmapped_rdata", last_rdata, 32'd0);
      chk("unmapped_hit", {31'd0, last_hit}, 32'd0);

      // High-half snapshot
      wr(12'hB80, 32'h0);
      wr(12'hB00, 32'hFFFF_FFFE);
      rd(12'hB00); chk("snap_lo", last_rdata, 32'hFFFF_FFFE);
      tick();
      rd(12'hB80);
`ifdef IBEX_PERF_HI_SNAPSHOT_EN
      chk("snap_hi", last_rdata, 32'd0);
`else
      chk("live_hi", last_rdata, 32'd1);
`endif

      // Reset in the middle of an access drops the response
      csr_req = 1'b1; csr_addr = 12'hB00; rst = 1'b1;
      tick();
      csr_req = 1'b0; rst = 1'b0;
      tick();
      rd(12'hB00); chk("after_mid_reset", last_rdata, 32'd1);

      // Randomized traffic against the model
      for (int t = 0; t < 400; t++) begin
         rst        = ($urandom_range(0, 99) == 0);
         csr_req    = ($urandom_range(0, 3) != 0);
         csr_we     = ($urandom_range(0, 3) == 0);
         csr_addr   = addr_tab[$urandom_range(0, 14)];
         csr_wdata  = $urandom;
         instr_ret  = $urandom_range(0, 1) == 1;
         hpm_event  = NUM_HPM'($urandom_range(0, 3));
         debug_mode = ($urandom_range(0, 7) == 0);
         stopcount  = ($urandom_range(0, 1) == 1);
         tick();
      end
      rst = 1'b0; csr_req = 1'b0; csr_we = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
